// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between NUM_REQ byte producers, the UART TX arbiter and the
// transmitter's byte-load port.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int REQ_IDX_W  = 2,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [NUM_REQ-1:0]            req_last_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [DATA_WIDTH-1:0]         tx_data_o;
    logic                          tx_valid_o;
    logic                          tx_accept_i;
    logic                          tx_done_i;
    logic [REQ_IDX_W-1:0]          grant_o;
    logic                          grant_valid_o;
    logic                          pkt_abort_o;

    // Arbiter side.
    modport slave (
        input  req_valid_i, req_data_i, req_last_i, tx_accept_i, tx_done_i,
        output req_ready_o, tx_data_o, tx_valid_o, grant_o, grant_valid_o, pkt_abort_o
    );

    // Producer/transmitter side.
    modport master (
        output req_valid_i, req_data_i, req_last_i, tx_accept_i, tx_done_i,
        input  req_ready_o, tx_data_o, tx_valid_o, grant_o, grant_valid_o, pkt_abort_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ producers,
// keeping multi-byte packets contiguous with an idle-timeout lock release.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int REQ_IDX_W    = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input logic              CLK,
    input logic              RSTN,
    uart_tx_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_e;

    state_e                state_q, state_d;
    logic [REQ_IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [REQ_IDX_W-1:0]  grant_q, grant_d;
    logic                  locked_q, locked_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  abort_q, abort_d;

    logic                  cand_found;
    logic [REQ_IDX_W-1:0]  cand_idx;
    logic [REQ_IDX_W-1:0]  sel_idx;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [REQ_IDX_W-1:0]  grant_next;

    // Rotating the doubled valid vector puts rr_ptr at bit 0, so the first set
    // bit is the round-robin candidate without a variable-width index.
    always_comb begin
        logic [2*NUM_REQ-1:0] valid_rot;
        int                   pos;
        // NOTE: every combinational output gets a default first; a missed branch would otherwise infer a latch.
        cand_found = 1'b0;
        cand_idx   = '0;
        pos        = 0;
        valid_rot  = {bus.req_valid_i, bus.req_valid_i} >> rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!cand_found && valid_rot[k]) begin
                cand_found = 1'b1;
                pos        = int'(rr_ptr_q) + k;
                if (pos >= NUM_REQ) pos = pos - NUM_REQ;
                cand_idx   = REQ_IDX_W'(pos);
            end
        end
    end

    always_comb begin
        sel_idx   = (state_q == HOLD) ? grant_q : cand_idx;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (REQ_IDX_W'(i) == sel_idx) begin
                sel_valid = bus.req_valid_i[i];
                sel_last  = bus.req_last_i[i];
                sel_data  = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = (state_q == HOLD) || (state_q == IDLE && cand_found);
            end
        end
    end

    assign grant_next = (grant_q == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + REQ_IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        locked_d    = locked_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        abort_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cand_found) begin
                    hold_data_d = sel_data;
                    grant_d     = cand_idx;
                    locked_d    = !sel_last;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                if (bus.tx_accept_i) state_d = WAIT;
            end
            WAIT: begin
                if (bus.tx_done_i) begin
                    if (locked_q) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        rr_ptr_d = grant_next;
                        state_d  = IDLE;
                    end
                end
            end
            HOLD: begin
                // A byte arriving on the final count wins over the timeout.
                if (sel_valid) begin
                    hold_data_d = sel_data;
                    locked_d    = !sel_last;
                    state_d     = LOAD;
                end else if (cnt_q == CNT_LAST) begin
                    abort_d  = 1'b1;
                    locked_d = 1'b0;
                    rr_ptr_d = grant_next;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            locked_q    <= 1'b0;
            cnt_q       <= '0;
            hold_data_q <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            locked_q    <= locked_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            abort_q     <= abort_d;
        end
    end

    assign bus.req_ready_o   = req_ready;
    assign bus.tx_valid_o    = (state_q == LOAD);
    assign bus.tx_data_o     = hold_data_q;
    assign bus.grant_o       = grant_q;
    assign bus.grant_valid_o = (state_q != IDLE);
    assign bus.pkt_abort_o   = abort_q;
endmodule
